// File: rtl/either_edge_detect_pkg.sv
// rtl/either_edge_detect_pkg.sv - shared constants and helpers for the either-edge detector
package either_edge_detect_pkg;

    localparam int SYNC_STAGES_MIN = 1;
    localparam int SYNC_STAGES_MAX = 4;

    // Out-of-range depths are pulled into the supported range.
    function automatic int clamp_stages(input int n);
        if (n < SYNC_STAGES_MIN) begin
            return SYNC_STAGES_MIN;
        end
        if (n > SYNC_STAGES_MAX) begin
            return SYNC_STAGES_MAX;
        end
        return n;
    endfunction

endpackage

// File: rtl/either_edge_detect_bit_sync.sv
// rtl/either_edge_detect_bit_sync.sv - STAGES-deep, WIDTH-wide synchronizer chain
module bit_sync #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= RESET_VAL;
            end
        end else begin
            r_sync[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign dout = r_sync[STAGES-1];

endmodule

// File: rtl/either_edge_detect.sv
// rtl/either_edge_detect.sv - synchronizes an async input and pulses on rising/falling/any edge
module either_edge_detect
    import either_edge_detect_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] either_edge,
    output logic [WIDTH-1:0] rising_edge,
    output logic [WIDTH-1:0] falling_edge
);

    localparam int STAGES = clamp_stages(SYNC_STAGES);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] r_prev;

    bit_sync #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_bit_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (w_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= RESET_VAL;
        end else begin
            r_prev <= w_sync;
        end
    end

    // Outputs depend only on flops so raw din never reaches the output path.
    assign either_edge  = w_sync ^ r_prev;
    assign rising_edge  = w_sync & ~r_prev;
    assign falling_edge = ~w_sync & r_prev;

endmodule

// File: tb/tb_either_edge_detect.sv
// tb/tb_either_edge_detect.sv - directed self-checking bench for either_edge_detect
module tb_either_edge_detect;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:0] din = 1'b0;
    logic [0:0] either_edge;
    logic [0:0] rising_edge;
    logic [0:0] falling_edge;

    int n_checks = 0;
    int n_errors = 0;

    either_edge_detect #(
        .WIDTH       (1),
        .SYNC_STAGES (2),
        .RESET_VAL   (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .either_edge  (either_edge),
        .rising_edge  (rising_edge),
        .falling_edge (falling_edge)
    );

    always #20 clk = ~clk;

    task automatic check1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check(input string tag, input logic exp_e, input logic exp_r, input logic exp_f);
        check1({tag, ".either"},  either_edge[0],  exp_e);
        check1({tag, ".rising"},  rising_edge[0],  exp_r);
        check1({tag, ".falling"}, falling_edge[0], exp_f);
    endtask

    initial begin
        // 1: reset with din=0, then steady 0
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("idle0_%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // 2: 0->1 three units before posedge k
        #17 din = 1'b1;
        @(negedge clk);
        check("rise_k", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rise_k1", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("rise_k2", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rise_hold", 1'b0, 1'b0, 1'b0);

        // 3: 1->0 held
        din = 1'b0;
        @(negedge clk);
        check("fall_k", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("fall_k1", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("fall_hold_%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // 4: glitch entirely between posedges
        #5 din = 1'b1;
        #3 din = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("glitch_%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // 5: toggle on consecutive samples 1,0,1,0
        din = 1'b1;
        @(negedge clk);
        check("tog_0", 1'b0, 1'b0, 1'b0);
        din = 1'b0;
        @(negedge clk);
        check("tog_1", 1'b1, 1'b1, 1'b0);
        din = 1'b1;
        @(negedge clk);
        check("tog_2", 1'b1, 1'b0, 1'b1);
        din = 1'b0;
        @(negedge clk);
        check("tog_3", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("tog_4", 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("tog_5", 1'b0, 1'b0, 1'b0);

        // 6: din=1 during reset, release, then reset mid-pulse
        rst = 1'b1;
        din = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_hold_%0d", i), 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rel_1", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rel_2", 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_mid_hold", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rel2_1", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rel2_2", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("rel2_3", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
